mc_maindec: RTL and testbench



---
 rtl/mc_ctrl_pkg.sv | 51 +++++
 rtl/mc_maindec.sv | 166 ++++++++++++++++
 tb/tb_mc_maindec.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, aluop, pcsrc, alusrcb, FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mc_ctrl_pkg;

  // Opcodes consumed by the main decoder
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // aluop field handed to the ALU function decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,
    S_ADDIWB = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } mc_state_t;

  // True for the states that hold a memory access open until mem_ready
  function automatic logic is_mem_state(input mc_state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_maindec.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/writeback and drives datapath enables.
// Latency: lw 5, sw/R-type/addi 4, beq/j 3 cycles with zero-wait memory; each memory wait cycle adds 1.
// Backpressure: FETCH/MEMRD/MEMWR hold until mem_ready; optional MEM_TIMEOUT abort. Macro MC_MAINDEC_BNE_EN enables bne.
module mc_maindec
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       err
);

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = (MEM_TIMEOUT > 0) ? TW'(MEM_TIMEOUT - 1) : '0;

  mc_state_t     state;
  logic [TW-1:0] tmo_cnt;
  logic          err_q;
  logic          mem_wait;
  logic          tmo_hit;
  logic          br_take;

  // A memory state is stalled when the access has not completed this cycle
  assign mem_wait = is_mem_state(state) && !mem_ready;
  assign tmo_hit  = (MEM_TIMEOUT > 0) && mem_wait && (tmo_cnt == TMO_LAST);

`ifdef MC_MAINDEC_BNE_EN
  logic bne_sense;

  // Remember in DECODE whether the branch is taken on zero or on non-zero
  always_ff @(posedge clk) begin
    if (!rst_n)
      bne_sense <= 1'b0;
    else if (state == S_DECODE)
      bne_sense <= (op == OP_BNE);
  end

  assign br_take = zero ^ bne_sense;
`else
  assign br_take = zero;
`endif

  // State sequencing, memory-wait timeout and sticky error flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      tmo_cnt <= (mem_wait && !tmo_hit) ? tmo_cnt + 1'b1 : '0;
      if (tmo_hit) begin
        err_q <= 1'b1;
        state <= S_FETCH;
      end else begin
        case (state)
          S_FETCH:  if (mem_ready) state <= S_DECODE;
          S_DECODE: begin
            case (op)
              OP_LW, OP_SW: state <= S_MEMADR;
              OP_RTYPE:     state <= S_EXEC;
              OP_ADDI:      state <= S_ADDIEX;
              OP_BEQ:       state <= S_BRANCH;
`ifdef MC_MAINDEC_BNE_EN
              OP_BNE:       state <= S_BRANCH;
`endif
              OP_J:         state <= S_JUMP;
              default: begin
                err_q <= 1'b1;
                state <= S_FETCH;
              end
            endcase
          end
          S_MEMADR: state <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
          S_MEMRD:  if (mem_ready) state <= S_MEMWB;
          S_MEMWR:  if (mem_ready) state <= S_FETCH;
          S_EXEC:   state <= S_ALUWB;
          S_ADDIEX: state <= S_ADDIWB;
          default:  state <= S_FETCH;
        endcase
      end
    end
  end

  // Moore decode of datapath controls; everything is held at 0 during reset
  always_comb begin
    mem_req  = 1'b0;
    memwrite = 1'b0;
    iord     = 1'b0;
    irwrite  = 1'b0;
    pcen     = 1'b0;
    pcsrc    = PCSRC_ALU;
    alusrca  = 1'b0;
    alusrcb  = SRCB_REG;
    aluop    = ALUOP_ADD;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          alusrcb = SRCB_FOUR;
          irwrite = mem_ready;
          pcen    = mem_ready;
        end
        S_DECODE: alusrcb = SRCB_IMMSH2;
        S_MEMADR, S_ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = SRCB_IMM;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        S_MEMWR: begin
          mem_req  = 1'b1;
          memwrite = 1'b1;
          iord     = 1'b1;
        end
        S_EXEC: begin
          alusrca = 1'b1;
          aluop   = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
        end
        S_ADDIWB: regwrite = 1'b1;
        S_BRANCH: begin
          alusrca = 1'b1;
          aluop   = ALUOP_SUB;
          pcsrc   = PCSRC_ALUOUT;
          pcen    = br_take;
        end
        S_JUMP: begin
          pcsrc = PCSRC_JUMP;
          pcen  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign err = err_q & rst_n;

endmodule

// File: tb/tb_mc_maindec.sv
// Directed bench for mc_maindec: walks every instruction class cycle by cycle against hand-built control words.
// Latency: checks each FSM cycle mid-period, one cycle at a time.
// Backpressure: memory waits and the MEM_TIMEOUT=4 abort are driven through mem_ready.
module tb_mc_maindec;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, memwrite, iord, irwrite, pcen;
  logic [1:0] pcsrc, alusrcb, aluop;
  logic       alusrca, regwrite, regdst, memtoreg, err;
  logic [14:0] ctl;

  int checks   = 0;
  int failures = 0;

  // Control word field order:
  // mem_req memwrite iord irwrite pcen pcsrc[2] alusrca alusrcb[2] aluop[2] regwrite regdst memtoreg
  localparam logic [14:0] E_RESET   = 15'b0_0_0_0_0_00_0_00_00_0_0_0;
  localparam logic [14:0] E_FETCH_R = 15'b1_0_0_1_1_00_0_01_00_0_0_0;
  localparam logic [14:0] E_FETCH_W = 15'b1_0_0_0_0_00_0_01_00_0_0_0;
  localparam logic [14:0] E_DECODE  = 15'b0_0_0_0_0_00_0_11_00_0_0_0;
  localparam logic [14:0] E_MEMADR  = 15'b0_0_0_0_0_00_1_10_00_0_0_0;
  localparam logic [14:0] E_MEMRD   = 15'b1_0_1_0_0_00_0_00_00_0_0_0;
  localparam logic [14:0] E_MEMWB   = 15'b0_0_0_0_0_00_0_00_00_1_0_1;
  localparam logic [14:0] E_MEMWR   = 15'b1_1_1_0_0_00_0_00_00_0_0_0;
  localparam logic [14:0] E_EXEC    = 15'b0_0_0_0_0_00_1_00_10_0_0_0;
  localparam logic [14:0] E_ALUWB   = 15'b0_0_0_0_0_00_0_00_00_1_1_0;
  localparam logic [14:0] E_ADDIWB  = 15'b0_0_0_0_0_00_0_00_00_1_0_0;
  localparam logic [14:0] E_BR_TK   = 15'b0_0_0_0_1_01_1_00_01_0_0_0;
  localparam logic [14:0] E_BR_NT   = 15'b0_0_0_0_0_01_1_00_01_0_0_0;
  localparam logic [14:0] E_JUMP    = 15'b0_0_0_0_1_10_0_00_00_0_0_0;

  mc_maindec #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .pcen(pcen), .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
    .err(err)
  );

  assign ctl = {mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca,
                alusrcb, aluop, regwrite, regdst, memtoreg};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance past the next edge
  task automatic cyc(input string tag, input logic rst, input logic [5:0] opc,
                     input logic z, input logic mr, input logic [14:0] exp_ctl,
                     input logic exp_err);
    rst_n     = rst;
    op        = opc;
    zero      = z;
    mem_ready = mr;
    #1;
    chk(tag, ctl, exp_ctl);
    chk({tag, "_err"}, {14'b0, err}, {14'b0, exp_err});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; op = 6'b0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset held with mem_ready high, then first cycle out of reset is FETCH
    cyc("rst0", 1'b0, 6'b100011, 1'b0, 1'b1, E_RESET, 1'b0);
    cyc("rst1", 1'b0, 6'b100011, 1'b0, 1'b1, E_RESET, 1'b0);

    // lw, zero-wait: 5 cycles
    cyc("lw_fetch",  1'b1, 6'b100011, 1'b0, 1'b1, E_FETCH_R, 1'b0);
    cyc("lw_decode", 1'b1, 6'b100011, 1'b0, 1'b1, E_DECODE,  1'b0);
    cyc("lw_memadr", 1'b1, 6'b100011, 1'b0, 1'b1, E_MEMADR,  1'b0);
    cyc("lw_memrd",  1'b1, 6'b100011, 1'b0, 1'b1, E_MEMRD,   1'b0);
    cyc("lw_memwb",  1'b1, 6'b100011, 1'b0, 1'b1, E_MEMWB,   1'b0);

    // sw with three wait cycles: memwrite stable for 4 cycles, then FETCH
    cyc("sw_fetch",  1'b1, 6'b101011, 1'b0, 1'b1, E_FETCH_R, 1'b0);
    cyc("sw_decode", 1'b1, 6'b101011, 1'b0, 1'b1, E_DECODE,  1'b0);
    cyc("sw_memadr", 1'b1, 6'b101011, 1'b0, 1'b1, E_MEMADR,  1'b0);
    cyc("sw_wait0",  1'b1, 6'b101011, 1'b0, 1'b0, E_MEMWR,   1'b0);
    cyc("sw_wait1",  1'b1, 6'b101011, 1'b0, 1'b0, E_MEMWR,   1'b0);
    cyc("sw_wait2",  1'b1, 6'b101011, 1'b0, 1'b0, E_MEMWR,   1'b0);
    cyc("sw_done",   1'b1, 6'b101011, 1'b0, 1'b1, E_MEMWR,   1'b0);

    // R-type
    cyc("r_fetch",  1'b1, 6'b000000, 1'b0, 1'b1, E_FETCH_R, 1'b0);
    cyc("r_decode", 1'b1, 6'b000000, 1'b0, 1'b1, E_DECODE,  1'b0);
    cyc("r_exec",   1'b1, 6'b000000, 1'b0, 1'b1, E_EXEC,    1'b0);
    cyc("r_aluwb",  1'b1, 6'b000000, 1'b0, 1'b1, E_ALUWB,   1'b0);

    // addi
    cyc("ai_fetch",  1'b1, 6'b001000, 1'b0, 1'b1, E_FETCH_R, 1'b0);
    cyc("ai_decode", 1'b1, 6'b001000, 1'b0, 1'b1, E_DECODE,  1'b0);
    cyc("ai_ex",     1'b1, 6'b001000, 1'b0, 1'b1, E_MEMADR,  1'b0);
    cyc("ai_wb",     1'b1, 6'b001000, 1'b0, 1'b1, E_ADDIWB,  1'b0);

    // beq taken, then not taken
    cyc("beq1_fetch",  1'b1, 6'b000100, 1'b1, 1'b1, E_FETCH_R, 1'b0);
    cyc("beq1_decode", 1'b1, 6'b000100, 1'b1, 1'b1, E_DECODE,  1'b0);
    cyc("beq1_branch", 1'b1, 6'b000100, 1'b1, 1'b1, E_BR_TK,   1'b0);
    cyc("beq0_fetch",  1'b1, 6'b000100, 1'b0, 1'b1, E_FETCH_R, 1'b0);
    cyc("beq0_decode", 1'b1, 6'b000100, 1'b0, 1'b1, E_DECODE,  1'b0);
    cyc("beq0_branch", 1'b1, 6'b000100, 1'b0, 1'b1, E_BR_NT,   1'b0);

    // jump
    cyc("j_fetch",  1'b1, 6'b000010, 1'b0, 1'b1, E_FETCH_R, 1'b0);
    cyc("j_decode", 1'b1, 6'b000010, 1'b0, 1'b1, E_DECODE,  1'b0);
    cyc("j_jump",   1'b1, 6'b000010, 1'b0, 1'b1, E_JUMP,    1'b0);

    // Illegal opcode: err rises after DECODE, back in FETCH
    cyc("ill_fetch",  1'b1, 6'b111111, 1'b0, 1'b1, E_FETCH_R, 1'b0);
    cyc("ill_decode", 1'b1, 6'b111111, 1'b0, 1'b1, E_DECODE,  1'b0);
    cyc("ill_after",  1'b1, 6'b111111, 1'b0, 1'b0, E_FETCH_W, 1'b1);
    cyc("ill_sticky", 1'b1, 6'b111111, 1'b0, 1'b1, E_FETCH_R, 1'b1);
    // err clears only on reset
    cyc("ill_rst",    1'b0, 6'b111111, 1'b0, 1'b1, E_RESET,   1'b0);

    // bne: inverted branch sense when enabled, illegal otherwise
    cyc("bne_fetch",  1'b1, 6'b000101, 1'b1, 1'b1, E_FETCH_R, 1'b0);
    cyc("bne_decode", 1'b1, 6'b000101, 1'b1, 1'b1, E_DECODE,  1'b0);
`ifdef MC_MAINDEC_BNE_EN
    cyc("bne_branch", 1'b1, 6'b000101, 1'b1, 1'b1, E_BR_NT,   1'b0);
    cyc("bne_fetch2", 1'b1, 6'b000101, 1'b0, 1'b1, E_FETCH_R, 1'b0);
    cyc("bne_dec2",   1'b1, 6'b000101, 1'b0, 1'b1, E_DECODE,  1'b0);
    cyc("bne_br2",    1'b1, 6'b000101, 1'b0, 1'b1, E_BR_TK,   1'b0);
`else
    cyc("bne_illegal", 1'b1, 6'b000101, 1'b1, 1'b1, E_FETCH_R, 1'b1);
`endif
    cyc("to_rst", 1'b0, 6'b000000, 1'b0, 1'b0, E_RESET, 1'b0);

    // Timeout: mem_ready stuck low in FETCH, err after the 4th stalled cycle
    cyc("to_f0", 1'b1, 6'b000000, 1'b0, 1'b0, E_FETCH_W, 1'b0);
    cyc("to_f1", 1'b1, 6'b000000, 1'b0, 1'b0, E_FETCH_W, 1'b0);
    cyc("to_f2", 1'b1, 6'b000000, 1'b0, 1'b0, E_FETCH_W, 1'b0);
    cyc("to_f3", 1'b1, 6'b000000, 1'b0, 1'b0, E_FETCH_W, 1'b0);
    cyc("to_f4", 1'b1, 6'b000000, 1'b0, 1'b0, E_FETCH_W, 1'b1);
    // Fetch restarts and completes normally, err stays sticky
    cyc("to_f5", 1'b1, 6'b000000, 1'b0, 1'b1, E_FETCH_R, 1'b1);
    cyc("to_dec", 1'b1, 6'b000000, 1'b0, 1'b1, E_DECODE, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
